song_sequencer: RTL and testbench

- Consumes the periodic 16-bit tempo pulse from the slow-pulse stage (bit 0 rising edge = one beat tick).
- Steps through a song stored in an external synchronous note ROM and presents the current note to the tone generator.
- Active only while song_select is high.
- Holds each note for a per-entry number of ticks and handles rests, an end-of-song marker, and optional looping.

---
 rtl/song_sequencer_if.sv | 33 +++
 rtl/song_sequencer.sv | 132 +++++++++++++
 tb/tb_song_sequencer.sv | 205 ++++++++++++++++++++
 3 files changed

// File: rtl/song_sequencer_if.sv
// Sequencer-facing bundle: enable, tempo pulse, note ROM read port and the note outputs.
// The slave modport is the sequencer side; the master modport is the surrounding system.
interface song_sequencer_if #(
  parameter int unsigned IDX_W = 5
);
  logic             song_select;
  logic [15:0]      pulse;
  logic [IDX_W-1:0] rom_addr;
  logic [9:0]       rom_data;
  logic [6:0]       note_out;
  logic             note_on;
  logic             song_done;

  modport master (
    output song_select,
    output pulse,
    output rom_data,
    input  rom_addr,
    input  note_out,
    input  note_on,
    input  song_done
  );

  modport slave (
    input  song_select,
    input  pulse,
    input  rom_data,
    output rom_addr,
    output note_out,
    output note_on,
    output song_done
  );
endinterface

// File: rtl/song_sequencer.sv
// Song sequencer: walks a note ROM on tempo ticks and drives the tone generator.
// Each entry lasts 1..4 ticks; supports rests, an end marker and optional looping.
module song_sequencer #(
  parameter int unsigned SONG_LEN = 32,
  parameter int unsigned IDX_W    = 5,
  parameter bit          LOOP     = 1'b0
) (
  input logic             clock,
  input logic             reset_n,
  song_sequencer_if.slave bus
);

  typedef enum logic [2:0] {StIdle, StFetch, StLoad, StPlay, StDone} state_e;

  localparam logic [9:0]       EndMarker = 10'h3FF;
  localparam logic [IDX_W-1:0] LastAddr  = IDX_W'(SONG_LEN - 1);

  state_e           state_q, state_d;
  logic [IDX_W-1:0] addr_q, addr_d;
  logic [6:0]       note_q, note_d;
  logic             on_q, on_d;
  logic [2:0]       rem_q, rem_d;
  logic             pend_q, pend_d;
  logic             pulse0_q;
  logic             tick;
  logic             unused_pulse;

  assign tick         = bus.pulse[0] & ~pulse0_q;
  assign unused_pulse = ^bus.pulse[15:1];

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= StIdle;
      addr_q   <= '0;
      note_q   <= '0;
      on_q     <= 1'b0;
      rem_q    <= '0;
      pend_q   <= 1'b0;
      pulse0_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      addr_q   <= addr_d;
      note_q   <= note_d;
      on_q     <= on_d;
      rem_q    <= rem_d;
      pend_q   <= pend_d;
      pulse0_q <= bus.pulse[0];
    end
  end

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    note_d  = note_q;
    on_d    = on_q;
    rem_d   = rem_q;
    pend_d  = pend_q;

    if (!bus.song_select) begin
      state_d = StIdle;
      addr_d  = '0;
      note_d  = '0;
      on_d    = 1'b0;
      rem_d   = '0;
      pend_d  = 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          addr_d  = '0;
          pend_d  = 1'b0;
          state_d = StFetch;
        end
        StFetch: begin
          pend_d  = pend_q | tick;
          state_d = StLoad;
        end
        StLoad: begin
          pend_d = pend_q | tick;
          if (bus.rom_data == EndMarker) begin
            // A marker at entry 0 would otherwise loop through FETCH forever.
            if (LOOP && addr_q != '0) begin
              addr_d  = '0;
              state_d = StFetch;
            end else begin
              note_d  = '0;
              on_d    = 1'b0;
              state_d = StDone;
            end
          end else begin
            rem_d   = {1'b0, bus.rom_data[9:8]} + 3'd1;
            note_d  = bus.rom_data[7] ? 7'd0 : bus.rom_data[6:0];
            on_d    = ~bus.rom_data[7];
            state_d = StPlay;
          end
        end
        StPlay: begin
          pend_d = 1'b0;
          // A pending tick and a fresh tick in the same cycle count once.
          if (tick | pend_q) begin
            if (rem_q > 3'd1) begin
              rem_d = rem_q - 3'd1;
            end else if (addr_q == LastAddr) begin
              if (LOOP) begin
                addr_d  = '0;
                state_d = StFetch;
              end else begin
                note_d  = '0;
                on_d    = 1'b0;
                state_d = StDone;
              end
            end else begin
              addr_d  = addr_q + 1'b1;
              state_d = StFetch;
            end
          end
        end
        StDone: begin
          pend_d = 1'b0;
          note_d = '0;
          on_d   = 1'b0;
        end
        default: state_d = StIdle;
      endcase
    end
  end

  assign bus.rom_addr  = addr_q;
  assign bus.note_out  = note_q;
  assign bus.note_on   = on_q;
  assign bus.song_done = (state_q == StDone);

endmodule

// File: tb/tb_song_sequencer.sv
// Directed bench for song_sequencer: a stop-at-end instance and a 4-entry looping instance,
// each fed from a synchronous ROM model.
module tb_song_sequencer;

  logic clock = 1'b0;
  logic reset_n;
  logic pulse_bit;

  always #5 clock = ~clock;

  song_sequencer_if #(.IDX_W(5)) bus0 ();
  song_sequencer_if #(.IDX_W(2)) bus1 ();

  assign bus0.pulse = {15'd0, pulse_bit};
  assign bus1.pulse = {15'd0, pulse_bit};

  song_sequencer #(.SONG_LEN(32), .IDX_W(5), .LOOP(1'b0)) dut0 (
    .clock   (clock),
    .reset_n (reset_n),
    .bus     (bus0)
  );

  song_sequencer #(.SONG_LEN(4), .IDX_W(2), .LOOP(1'b1)) dut1 (
    .clock   (clock),
    .reset_n (reset_n),
    .bus     (bus1)
  );

  logic [9:0] rom0 [32];
  logic [9:0] rom1 [4];

  always @(posedge clock) begin
    bus0.rom_data <= rom0[bus0.rom_addr];
    bus1.rom_data <= rom1[bus1.rom_addr];
  end

  int checks   = 0;
  int failures = 0;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  // One rising edge on pulse[0], consumed at the first clock edge.
  task automatic tick();
    pulse_bit = 1'b1;
    step(1);
    pulse_bit = 1'b0;
    step(1);
  endtask

  function automatic logic [9:0] ent(input logic [1:0] dur, input logic rest,
                                     input logic [6:0] note);
    return {dur, rest, note};
  endfunction

  initial begin
    reset_n          = 1'b0;
    pulse_bit        = 1'b0;
    bus0.song_select = 1'b0;
    bus1.song_select = 1'b0;
    for (int i = 0; i < 32; i++) rom0[i] = 10'h3FF;
    for (int i = 0; i < 4; i++) rom1[i] = ent(2'd0, 1'b0, 7'(40 + i));

    step(2);
    check_val("rst_addr", 32'(bus0.rom_addr), 0);
    check_val("rst_note_on", 32'(bus0.note_on), 0);
    check_val("rst_note_out", 32'(bus0.note_out), 0);
    check_val("rst_done", 32'(bus0.song_done), 0);
    reset_n = 1'b1;
    step(1);

    // Two notes then end marker.
    rom0[0] = ent(2'd0, 1'b0, 7'd60);
    rom0[1] = ent(2'd1, 1'b0, 7'd62);
    rom0[2] = 10'h3FF;
    bus0.song_select = 1'b1;
    step(2);
    check_val("lat_note_on_early", 32'(bus0.note_on), 0);
    step(1);
    check_val("a_note60", 32'(bus0.note_out), 60);
    check_val("a_on60", 32'(bus0.note_on), 1);
    tick();
    step(1);
    check_val("a_note62", 32'(bus0.note_out), 62);
    check_val("a_addr1", 32'(bus0.rom_addr), 1);
    tick();
    tick();
    step(1);
    check_val("a_done", 32'(bus0.song_done), 1);
    check_val("a_done_on", 32'(bus0.note_on), 0);
    check_val("a_done_note", 32'(bus0.note_out), 0);
    check_val("a_done_addr", 32'(bus0.rom_addr), 2);
    bus0.song_select = 1'b0;
    step(1);
    check_val("a_idle_done", 32'(bus0.song_done), 0);
    check_val("a_idle_addr", 32'(bus0.rom_addr), 0);

    // Rest, normal notes, 4-tick hold, drop select at entry 2 and replay.
    rom0[0] = ent(2'd0, 1'b1, 7'd5);
    rom0[1] = ent(2'd0, 1'b0, 7'd64);
    rom0[2] = ent(2'd3, 1'b0, 7'd67);
    rom0[3] = 10'h3FF;
    bus0.song_select = 1'b1;
    step(3);
    check_val("b_rest_on", 32'(bus0.note_on), 0);
    check_val("b_rest_note", 32'(bus0.note_out), 0);
    tick();
    step(1);
    check_val("b_note64", 32'(bus0.note_out), 64);
    check_val("b_on64", 32'(bus0.note_on), 1);
    tick();
    step(1);
    check_val("b_note67", 32'(bus0.note_out), 67);
    tick();
    tick();
    tick();
    check_val("b_hold_note", 32'(bus0.note_out), 67);
    check_val("b_hold_addr", 32'(bus0.rom_addr), 2);
    bus0.song_select = 1'b0;
    step(1);
    check_val("b_drop_on", 32'(bus0.note_on), 0);
    check_val("b_drop_addr", 32'(bus0.rom_addr), 0);
    check_val("b_drop_note", 32'(bus0.note_out), 0);
    bus0.song_select = 1'b1;
    step(3);
    check_val("b_replay_addr", 32'(bus0.rom_addr), 0);
    tick();
    step(1);
    check_val("b_replay_note", 32'(bus0.note_out), 64);

    // Asynchronous reset between clock edges while playing.
    #2;
    reset_n = 1'b0;
    #1;
    check_val("r_async_on", 32'(bus0.note_on), 0);
    check_val("r_async_note", 32'(bus0.note_out), 0);
    check_val("r_async_addr", 32'(bus0.rom_addr), 0);
    bus0.song_select = 1'b0;
    #1;
    reset_n = 1'b1;
    step(1);
    check_val("r_rel_addr", 32'(bus0.rom_addr), 0);
    check_val("r_rel_on", 32'(bus0.note_on), 0);
    check_val("r_rel_done", 32'(bus0.song_done), 0);

    // Tick during FETCH becomes pending; long-held pulse decrements once.
    rom0[0] = ent(2'd0, 1'b0, 7'd70);
    rom0[1] = ent(2'd1, 1'b0, 7'd72);
    rom0[2] = ent(2'd0, 1'b0, 7'd74);
    rom0[3] = 10'h3FF;
    bus0.song_select = 1'b1;
    step(1);
    pulse_bit = 1'b1;
    step(1);
    pulse_bit = 1'b0;
    step(1);
    check_val("c_note70", 32'(bus0.note_out), 70);
    step(1);
    check_val("c_pend_addr", 32'(bus0.rom_addr), 1);
    step(2);
    check_val("c_note72", 32'(bus0.note_out), 72);
    pulse_bit = 1'b1;
    step(30);
    check_val("c_held_note", 32'(bus0.note_out), 72);
    check_val("c_held_addr", 32'(bus0.rom_addr), 1);
    pulse_bit = 1'b0;
    step(1);
    tick();
    step(1);
    check_val("c_note74", 32'(bus0.note_out), 74);
    check_val("c_addr2", 32'(bus0.rom_addr), 2);
    tick();
    step(1);
    check_val("c_done", 32'(bus0.song_done), 1);

    // Looping 4-entry instance wraps and never finishes.
    check_val("d_pre_done", 32'(bus1.song_done), 0);
    bus1.song_select = 1'b1;
    step(3);
    check_val("d_note0", 32'(bus1.note_out), 40);
    check_val("d_addr0", 32'(bus1.rom_addr), 0);
    for (int i = 1; i <= 4; i++) begin
      tick();
      step(1);
      check_val("d_loop_addr", 32'(bus1.rom_addr), 32'(i % 4));
      check_val("d_loop_note", 32'(bus1.note_out), 32'(40 + (i % 4)));
      check_val("d_loop_done", 32'(bus1.song_done), 0);
    end
    check_val("d_dut0_done", 32'(bus0.song_done), 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
